pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the stall and flush event counters.
REQ-002 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have ports RS1_D and RS2_D, input, 5 each: source register numbers of the instruction in decode.
REQ-005 SHALL have ports USE_RS1_D and USE_RS2_D, input, 1 each: the decode instruction reads that source.
REQ-006 SHALL have ports RD_DE, RegWrite_DE and MemRead_DE, input, 5/1/1: destination register, write-enable and load flag in EX.
REQ-007 SHALL have ports RD_EM and RegWrite_EM, input, 5/1: destination register and write-enable in MEM.
REQ-008 SHALL have port isBranch_E, input, 1: taken branch or jump resolved in EX.
REQ-009 SHALL have port MEM_BUSY, input, 1: data memory not ready this cycle.
REQ-010 SHALL have outputs STALL_F and STALL_D, 1 each: hold the PC and the IF/ID register.
REQ-011 SHALL have outputs STALL_E and STALL_M, 1 each: hold the ID/EX and EX/MEM registers.
REQ-012 SHALL have outputs FLUSH_D and FLUSH_E, 1 each: insert a bubble into IF/ID and ID/EX.
REQ-013 SHALL have output REDIRECT_F, 1: IF loads the branch target.
REQ-014 SHALL have outputs FWD1_SEL_E and FWD2_SEL_E, 2 each, registered: EX source select, 0=register file, 1=EX/MEM, 2=MEM/WB.
REQ-015 SHALL have outputs STALL_CNT and FLUSH_CNT, CNT_W each: event counters.
REQ-016 SHALL have output STATE, 2: current FSM state.

Function
REQ-017 SHALL define a load-use hazard as MemRead_DE & RegWrite_DE & RD_DE!=0 & ((USE_RS1_D & RS1_D==RD_DE) | (USE_RS2_D & RS2_D==RD_DE)).
REQ-018 SHALL apply this priority: MEM_BUSY > isBranch_E > load-use.
REQ-019 SHALL, while MEM_BUSY=1, assert STALL_F/D/E/M, deassert all flushes and REDIRECT_F, and hold the FWD registers.
REQ-020 SHALL, on isBranch_E=1 with MEM_BUSY=0, assert REDIRECT_F, FLUSH_D and FLUSH_E in the same cycle and suppress any load-use stall.
REQ-021 SHALL, on a load-use hazard with neither higher-priority event, assert STALL_F, STALL_D and FLUSH_E for exactly one cycle.
REQ-022 SHALL drive all stall, flush and redirect outputs combinationally from the current inputs, with zero latency.
REQ-023 SHALL, on each edge where ID/EX advances (STALL_E=0, FLUSH_E=0), load FWDn_SEL_E as follows:
- 1 if RegWrite_DE, RD_DE!=0 and RD_DE==RSn_D;
- else 2 if RegWrite_EM, RD_EM!=0 and RD_EM==RSn_D;
- else 0.
REQ-024 SHALL load FWDn_SEL_E with 0 on an edge where FLUSH_E=1 and STALL_E=0.
REQ-025 SHALL never produce FWDn_SEL_E=3, and SHALL never forward register x0.
REQ-026 SHALL implement FSM states RUN=0, LDSTALL=1, BRFLUSH=2 and MEMWAIT=3, with the next state taken from the winning event of REQ-018, or RUN if there is no event.
REQ-027 SHALL increment STALL_CNT on every edge whose current cycle asserts STALL_F, saturating at all-ones.
REQ-028 SHALL increment FLUSH_CNT on every edge whose current cycle has REDIRECT_F=1, saturating at all-ones.
REQ-029 SHALL let a load-use hazard that is still present after MEMWAIT exits stall for its single cycle at that point.

Reset
REQ-030 SHALL, while rst_n=0, force STATE=RUN, FWD1_SEL_E=0, FWD2_SEL_E=0, STALL_CNT=0 and FLUSH_CNT=0, independent of clk.
REQ-031 SHALL, when reset is asserted mid-stall or mid-flush, discard the pending event with no residual stall cycle after release.

Structure
REQ-032 SHALL place the FSM state encodings and FWD_RF/FWD_EM/FWD_MW constants in the shared riscv.vh header.
REQ-033 SHALL instantiate sub-module fwd_sel once per source operand; it computes the 2-bit select combinationally.
REQ-034 SHALL keep forwarding data muxing in the EX datapath and not inside this block.

Verification
REQ-035 SHALL cover: lw x5 in EX, add using x5 in decode -> one cycle of STALL_F=STALL_D=FLUSH_E=1, STATE=1, STALL_CNT +1, then FWD1_SEL_E=2.
REQ-036 SHALL cover: RegWrite_DE=1, RD_DE=3, RS2_D=3 -> FWD2_SEL_E=1 after the edge; the same with RD_DE=0 -> FWD2_SEL_E=0.
REQ-037 SHALL cover: EX and MEM both writing x7, RS1_D=7 -> FWD1_SEL_E=1 (EX priority).
REQ-038 SHALL cover: isBranch_E=1 together with a load-use hazard -> REDIRECT_F=FLUSH_D=FLUSH_E=1, STALL_F=0, FLUSH_CNT +1.
REQ-039 SHALL cover: MEM_BUSY=1 for 3 cycles with isBranch_E=1 -> all stalls high and REDIRECT_F=0 for 3 cycles, then REDIRECT_F=1 in cycle 4, STALL_CNT +3.
REQ-040 SHALL cover: rst_n low mid-LDSTALL with counters preloaded to all-ones -> immediate STATE=0 and counters 0; saturation at all-ones checked before the reset.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state
// encodings and forwarding-select codes used by the EX operand muxes.
package pipe_ctrl_pkg;

    // Controller state; the value is the event that won the previous cycle.
    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_LDSTALL = 2'd1,
        ST_BRFLUSH = 2'd2,
        ST_MEMWAIT = 2'd3
    } state_t;

    // EX operand source select codes.
    localparam logic [1:0] FWD_RF = 2'd0;  // register file value
    localparam logic [1:0] FWD_EM = 2'd1;  // EX/MEM pipeline register
    localparam logic [1:0] FWD_MW = 2'd2;  // MEM/WB pipeline register

endpackage

// File: rtl/pipe_ctrl_fwd_sel.sv
// Forwarding select for one source operand. The youngest producer (the
// instruction currently in EX) wins over the one in MEM; x0 is never forwarded.
module fwd_sel
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] rs_i,
    input  logic [4:0] rd_de_i,
    input  logic       regwrite_de_i,
    input  logic [4:0] rd_em_i,
    input  logic       regwrite_em_i,
    output logic [1:0] sel_o
);

    // Priority select: EX producer, then MEM producer, else register file.
    always_comb begin
        sel_o = FWD_RF;
        if (regwrite_de_i && (rd_de_i != 5'd0) && (rd_de_i == rs_i)) begin
            sel_o = FWD_EM;
        end else if (regwrite_em_i && (rd_em_i != 5'd0) && (rd_em_i == rs_i)) begin
            sel_o = FWD_MW;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: resolves memory-wait, taken-branch and
// load-use events into stall/flush/redirect controls, registers the EX
// forwarding selects and counts stall and redirect cycles.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       RS1_D,
    input  logic [4:0]       RS2_D,
    input  logic             USE_RS1_D,
    input  logic             USE_RS2_D,
    input  logic [4:0]       RD_DE,
    input  logic             RegWrite_DE,
    input  logic             MemRead_DE,
    input  logic [4:0]       RD_EM,
    input  logic             RegWrite_EM,
    input  logic             isBranch_E,
    input  logic             MEM_BUSY,
    output logic             STALL_F,
    output logic             STALL_D,
    output logic             STALL_E,
    output logic             STALL_M,
    output logic             FLUSH_D,
    output logic             FLUSH_E,
    output logic             REDIRECT_F,
    output logic [1:0]       FWD1_SEL_E,
    output logic [1:0]       FWD2_SEL_E,
    output logic [CNT_W-1:0] STALL_CNT,
    output logic [CNT_W-1:0] FLUSH_CNT,
    output logic [1:0]       STATE
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state_q, state_d;
    logic [1:0][1:0]  fwd_q;
    logic [1:0][1:0]  fwd_d;
    logic [1:0][4:0]  rs_src;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             load_use_hazard;
    logic             load_use;

    assign rs_src[0] = RS1_D;
    assign rs_src[1] = RS2_D;

    // One select generator per source operand.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            fwd_sel u_fwd_sel (
                .rs_i          (rs_src[gi]),
                .rd_de_i       (RD_DE),
                .regwrite_de_i (RegWrite_DE),
                .rd_em_i       (RD_EM),
                .regwrite_em_i (RegWrite_EM),
                .sel_o         (fwd_d[gi])
            );
        end
    endgenerate

    // A load in EX whose result is needed by decode. The stall lasts a single
    // cycle: if the previous cycle was already the load-use bubble, the same
    // hazard is not stalled again (the load has moved on to MEM by then).
    always_comb begin
        load_use_hazard = MemRead_DE && RegWrite_DE && (RD_DE != 5'd0) &&
                          ((USE_RS1_D && (RS1_D == RD_DE)) ||
                           (USE_RS2_D && (RS2_D == RD_DE)));
        load_use = load_use_hazard && (state_q != ST_LDSTALL);
    end

    // Event priority: memory wait, then taken branch, then load-use.
    always_comb begin
        STALL_F    = 1'b0;
        STALL_D    = 1'b0;
        STALL_E    = 1'b0;
        STALL_M    = 1'b0;
        FLUSH_D    = 1'b0;
        FLUSH_E    = 1'b0;
        REDIRECT_F = 1'b0;
        state_d    = ST_RUN;
        if (MEM_BUSY) begin
            STALL_F = 1'b1;
            STALL_D = 1'b1;
            STALL_E = 1'b1;
            STALL_M = 1'b1;
            state_d = ST_MEMWAIT;
        end else if (isBranch_E) begin
            REDIRECT_F = 1'b1;
            FLUSH_D    = 1'b1;
            FLUSH_E    = 1'b1;
            state_d    = ST_BRFLUSH;
        end else if (load_use) begin
            STALL_F = 1'b1;
            STALL_D = 1'b1;
            FLUSH_E = 1'b1;
            state_d = ST_LDSTALL;
        end
    end

    // Saturating next values for the event counters.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (STALL_F && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (REDIRECT_F && (flush_cnt_q != CNT_MAX)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    // State, counters and forwarding selects; selects follow ID/EX, so they
    // hold while EX is stalled and clear when a bubble is inserted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            fwd_q       <= {FWD_RF, FWD_RF};
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            if (!STALL_E) begin
                if (FLUSH_E) begin
                    fwd_q <= {FWD_RF, FWD_RF};
                end else begin
                    fwd_q <= fwd_d;
                end
            end
        end
    end

    assign FWD1_SEL_E = fwd_q[0];
    assign FWD2_SEL_E = fwd_q[1];
    assign STALL_CNT  = stall_cnt_q;
    assign FLUSH_CNT  = flush_cnt_q;
    assign STATE      = state_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus randomized
// traffic, all compared against a cycle-level behavioural model.
module tb_pipe_ctrl;

    localparam int CW   = 4;
    localparam int SMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [4:0]    RS1_D, RS2_D, RD_DE, RD_EM;
    logic          USE_RS1_D, USE_RS2_D, RegWrite_DE, MemRead_DE, RegWrite_EM;
    logic          isBranch_E, MEM_BUSY;
    logic          STALL_F, STALL_D, STALL_E, STALL_M, FLUSH_D, FLUSH_E, REDIRECT_F;
    logic [1:0]    FWD1_SEL_E, FWD2_SEL_E, STATE;
    logic [CW-1:0] STALL_CNT, FLUSH_CNT;

    always #5 clk = ~clk;

    pipe_ctrl #(.CNT_W(CW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .RS1_D       (RS1_D),
        .RS2_D       (RS2_D),
        .USE_RS1_D   (USE_RS1_D),
        .USE_RS2_D   (USE_RS2_D),
        .RD_DE       (RD_DE),
        .RegWrite_DE (RegWrite_DE),
        .MemRead_DE  (MemRead_DE),
        .RD_EM       (RD_EM),
        .RegWrite_EM (RegWrite_EM),
        .isBranch_E  (isBranch_E),
        .MEM_BUSY    (MEM_BUSY),
        .STALL_F     (STALL_F),
        .STALL_D     (STALL_D),
        .STALL_E     (STALL_E),
        .STALL_M     (STALL_M),
        .FLUSH_D     (FLUSH_D),
        .FLUSH_E     (FLUSH_E),
        .REDIRECT_F  (REDIRECT_F),
        .FWD1_SEL_E  (FWD1_SEL_E),
        .FWD2_SEL_E  (FWD2_SEL_E),
        .STALL_CNT   (STALL_CNT),
        .FLUSH_CNT   (FLUSH_CNT),
        .STATE       (STATE)
    );

    int total = 0;
    int bad   = 0;
    int txn   = 0;

    // Reference model: event of last cycle, EX selects, counters.
    int m_state, m_f1, m_f2, m_sc, m_fc;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d (txn %0d)", tag, obs, exp, txn);
        end
    endtask

    // Which earlier stage supplies register rs: 1=EX result, 2=MEM result, 0=none.
    function automatic int src_of(input logic [4:0] rs, input logic [4:0] rdde, input logic rwde,
                                  input logic [4:0] rdem, input logic rwem);
        if (rwde && rdde != 0 && rdde == rs) return 1;
        if (rwem && rdem != 0 && rdem == rs) return 2;
        return 0;
    endfunction

    task automatic model_reset();
        m_state = 0; m_f1 = 0; m_f2 = 0; m_sc = 0; m_fc = 0;
    endtask

    // Asynchronous reset pulse started mid-cycle; entered and left at posedge+1.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_val("rst_state", 32'(STATE), 0);
        check_val("rst_fwd1", 32'(FWD1_SEL_E), 0);
        check_val("rst_fwd2", 32'(FWD2_SEL_E), 0);
        check_val("rst_scnt", 32'(STALL_CNT), 0);
        check_val("rst_fcnt", 32'(FLUSH_CNT), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // One clock cycle of stimulus; entered at posedge+1, compared at negedge.
    task automatic step(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1, input logic u2,
                        input logic [4:0] rdde, input logic rwde, input logic mrde,
                        input logic [4:0] rdem, input logic rwem, input logic br, input logic busy);
        int  ev;
        bit  hazard, st_fd, st_em, fl_e, red;
        RS1_D = rs1; RS2_D = rs2; USE_RS1_D = u1; USE_RS2_D = u2;
        RD_DE = rdde; RegWrite_DE = rwde; MemRead_DE = mrde;
        RD_EM = rdem; RegWrite_EM = rwem; isBranch_E = br; MEM_BUSY = busy;
        #4;
        txn++;
        hazard = mrde && rwde && rdde != 0 && ((u1 && rs1 == rdde) || (u2 && rs2 == rdde));
        // A load-use hazard gets exactly one bubble; it does not stall twice in a row.
        if (busy)                         ev = 3;
        else if (br)                      ev = 2;
        else if (hazard && m_state != 1)  ev = 1;
        else                              ev = 0;
        st_fd = (ev == 3) || (ev == 1);
        st_em = (ev == 3);
        fl_e  = (ev == 2) || (ev == 1);
        red   = (ev == 2);
        $display("txn %0d: busy=%0b br=%0b haz=%0b ev=%0d st=%0d f1=%0d f2=%0d sc=%0d fc=%0d",
                 txn, busy, br, hazard, ev, STATE, FWD1_SEL_E, FWD2_SEL_E, STALL_CNT, FLUSH_CNT);
        check_val("state",    32'(STATE), m_state);
        check_val("fwd1",     32'(FWD1_SEL_E), m_f1);
        check_val("fwd2",     32'(FWD2_SEL_E), m_f2);
        check_val("stall_cnt", 32'(STALL_CNT), m_sc);
        check_val("flush_cnt", 32'(FLUSH_CNT), m_fc);
        check_val("stall_f",  32'(STALL_F), 32'(st_fd));
        check_val("stall_d",  32'(STALL_D), 32'(st_fd));
        check_val("stall_e",  32'(STALL_E), 32'(st_em));
        check_val("stall_m",  32'(STALL_M), 32'(st_em));
        check_val("flush_d",  32'(FLUSH_D), 32'(red));
        check_val("flush_e",  32'(FLUSH_E), 32'(fl_e));
        check_val("redirect", 32'(REDIRECT_F), 32'(red));
        @(posedge clk);
        if (!st_em) begin
            if (fl_e) begin
                m_f1 = 0; m_f2 = 0;
            end else begin
                m_f1 = src_of(rs1, rdde, rwde, rdem, rwem);
                m_f2 = src_of(rs2, rdde, rwde, rdem, rwem);
            end
        end
        if (st_fd && m_sc < SMAX) m_sc++;
        if (red && m_fc < SMAX)   m_fc++;
        m_state = ev;
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Load x5 in EX, decode reads x5.
    task automatic lu_step();
        step(5, 0, 1, 0, 5, 1, 1, 0, 0, 0, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        RS1_D = 0; RS2_D = 0; USE_RS1_D = 0; USE_RS2_D = 0;
        RD_DE = 0; RegWrite_DE = 0; MemRead_DE = 0;
        RD_EM = 0; RegWrite_EM = 0; isBranch_E = 0; MEM_BUSY = 0;
        model_reset();
        #1;
        do_reset();

        // Load-use: one bubble, then the load result comes from MEM/WB.
        lu_step();
        check_val("lu_state", 32'(STATE), 1);
        check_val("lu_scnt", 32'(STALL_CNT), 1);
        step(5, 0, 1, 0, 0, 0, 0, 5, 1, 0, 0);
        check_val("lu_fwd1", 32'(FWD1_SEL_E), 2);
        check_val("lu_state_after", 32'(STATE), 0);

        // EX forwarding on rs2, and never from x0.
        step(0, 3, 0, 1, 3, 1, 0, 0, 0, 0, 0);
        check_val("ex_fwd2", 32'(FWD2_SEL_E), 1);
        step(0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0);
        check_val("x0_fwd2", 32'(FWD2_SEL_E), 0);

        // EX and MEM both write x7: EX wins.
        step(7, 0, 1, 0, 7, 1, 0, 7, 1, 0, 0);
        check_val("prio_fwd1", 32'(FWD1_SEL_E), 1);

        // Branch together with a load-use hazard.
        do_reset();
        step(5, 0, 1, 0, 5, 1, 1, 0, 0, 1, 0);
        check_val("br_fcnt", 32'(FLUSH_CNT), 1);
        check_val("br_scnt", 32'(STALL_CNT), 0);
        check_val("br_state", 32'(STATE), 2);

        // Memory wait over a pending branch for 3 cycles, then redirect.
        do_reset();
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        check_val("mw_scnt", 32'(STALL_CNT), 3);
        check_val("mw_fcnt", 32'(FLUSH_CNT), 0);
        check_val("mw_state", 32'(STATE), 3);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        check_val("mw_redirect_cnt", 32'(FLUSH_CNT), 1);

        // Load-use hazard waiting behind a memory wait stalls once afterwards.
        do_reset();
        step(5, 0, 1, 0, 5, 1, 1, 0, 0, 0, 1);
        step(5, 0, 1, 0, 5, 1, 1, 0, 0, 0, 1);
        lu_step();
        check_val("mwlu_state", 32'(STATE), 1);
        check_val("mwlu_scnt", 32'(STALL_CNT), 3);

        // Saturation, then reset in the middle of a load-use stall.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            lu_step();
            idle();
        end
        check_val("sat_scnt", 32'(STALL_CNT), SMAX);
        for (int i = 0; i < 16; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        check_val("sat_fcnt", 32'(FLUSH_CNT), SMAX);
        lu_step();
        check_val("pre_rst_state", 32'(STATE), 1);
        do_reset();
        idle();

        // Randomized traffic with small register numbers to provoke collisions.
        for (int n = 0; n < 400; n++) begin
            if (n % 60 == 59) do_reset();
            step(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 4) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
